// File: rtl/mux_4to1_pkg.sv
// ---------------------------------------------------------------------------
// mux_4to1_pkg
// Shared definitions for the registered 4:1 multiplexer.
//   sel_e      : 2-bit select code (SEL_A..SEL_D map to inputs a..d)
//   DEFAULT_N  : default data width of the multiplexer
// ---------------------------------------------------------------------------
package mux_4to1_pkg;

    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } sel_e;

    localparam int unsigned DEFAULT_N = 4;

endpackage

// File: rtl/mux_4to1_sel.sv
// ---------------------------------------------------------------------------
// mux_4to1_sel
// Purely combinational 4:1 selector, no clock.
// Ports:
//   a, b, c, d : N-bit data inputs
//   fn_sel     : 2-bit select code (0->a, 1->b, 2->c, 3->d)
//   y          : N-bit selected data
// ---------------------------------------------------------------------------
module mux_4to1_sel
    import mux_4to1_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [1:0]   fn_sel,
    output logic [N-1:0] y
);

    // Parallel case over a fully decoded 2-bit code: only the selected
    // input reaches y, so an X on an unselected input never propagates.
    always_comb begin
        y = '0;
        unique case (sel_e'(fn_sel))
            SEL_A: y = a;
            SEL_B: y = b;
            SEL_C: y = c;
            SEL_D: y = d;
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// ---------------------------------------------------------------------------
// mux_4to1
// Registered 4:1 multiplexer with capture enable.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   a..d      : N-bit data inputs
//   fn_sel    : 2-bit select code
//   en        : capture enable
//   out       : registered selected data (1-cycle latency)
//   out_sel   : fn_sel captured together with out
//   out_valid : en registered every cycle
//   out_par   : XOR of the bits loaded into out (only with MUX_4TO1_PARITY_EN)
// Configuration macro: MUX_4TO1_PARITY_EN adds the out_par output.
// ---------------------------------------------------------------------------
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [1:0]   fn_sel,
    input  logic         en,
    output logic [N-1:0] out,
    output logic [1:0]   out_sel,
    output logic         out_valid
`ifdef MUX_4TO1_PARITY_EN
    ,
    output logic         out_par
`endif
);

    logic [N-1:0] sel_y;

    logic [N-1:0] out_d, out_q;
    logic [1:0]   sel_d, sel_q;
    logic         valid_d, valid_q;

    mux_4to1_sel #(
        .N (N)
    ) u_sel (
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .fn_sel (fn_sel),
        .y      (sel_y)
    );

`ifdef MUX_4TO1_PARITY_EN
    logic par_d, par_q;

    always_comb begin
        par_d = par_q;
        if (en) begin
            par_d = ^sel_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`endif

    always_comb begin
        out_d   = out_q;
        sel_d   = sel_q;
        valid_d = en;
        if (en) begin
            out_d = sel_y;
            sel_d = fn_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_4to1.sv
// ---------------------------------------------------------------------------
// tb_mux_4to1
// Self-checking bench for mux_4to1 (N=4) with a behavioural reference model.
// Build with MUX_4TO1_PARITY_EN defined to also exercise out_par.
// ---------------------------------------------------------------------------
module tb_mux_4to1;

    logic       clk;
    logic       rst_n;
    logic [3:0] a, b, c, d;
    logic [1:0] fn_sel;
    logic       en;
    logic [3:0] out;
    logic [1:0] out_sel;
    logic       out_valid;
`ifdef MUX_4TO1_PARITY_EN
    logic       out_par;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_out;
    logic [1:0] m_sel;
    logic       m_valid;
    logic       m_par;

    mux_4to1 #(
        .N (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .fn_sel    (fn_sel),
        .en        (en),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid)
`ifdef MUX_4TO1_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, 64'(out), 64'(m_out));
        check({tag, ".out_sel"}, 64'(out_sel), 64'(m_sel));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
`ifdef MUX_4TO1_PARITY_EN
        check({tag, ".out_par"}, 64'(out_par), 64'(m_par));
`endif
    endtask

    // Reference: the selected operand is simply element fn_sel of the
    // input list; parity is the count of ones modulo 2.
    task automatic model_edge();
        logic [3:0] ops [4];
        int ones;
        ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
        if (!rst_n) begin
            m_out = 0; m_sel = 0; m_valid = 0; m_par = 0;
        end else begin
            m_valid = en;
            if (en) begin
                m_out = ops[int'(fn_sel) % 4];
                m_sel = fn_sel;
                ones = 0;
                for (int i = 0; i < 4; i++) ones += int'(m_out[i]);
                m_par = (ones % 2) == 1;
            end
        end
    endtask

    // One clock: model follows the edge, inputs are optionally disturbed
    // after the edge, outputs are compared on the falling edge.
    task automatic cycle(input string tag, input bit scramble);
        @(posedge clk);
        model_edge();
        if (scramble) begin
            #1;
            a = 4'($urandom); b = 4'($urandom);
            c = 4'($urandom); d = 4'($urandom);
            fn_sel = 2'($urandom);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int wide_sel;
        rst_n = 1'b0; en = 1'b0; fn_sel = '0;
        a = '0; b = '0; c = '0; d = '0;
        m_out = 0; m_sel = 0; m_valid = 0; m_par = 0;

        // Held in reset while inputs toggle
        for (int i = 0; i < 5; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            c = 4'($urandom); d = 4'($urandom);
            fn_sel = 2'($urandom); en = 1'($urandom);
            cycle("reset", 1'b1);
        end
        rst_n = 1'b1;

        // Select sweep, back-to-back enabled cycles
        a = 4'h4; b = 4'h1; c = 4'h9; d = 4'h3; en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            fn_sel = 2'(s);
            cycle("sweep", 1'b0);
        end
        check("sweep_last", 64'(out), 64'h3);
`ifdef MUX_4TO1_PARITY_EN
        check("par_d", 64'(out_par), 64'h0);
        fn_sel = 2'd1;
        cycle("par_b_cyc", 1'b0);
        check("par_b", 64'(out_par), 64'h1);
`endif

        // Wide select value truncated to its low 2 bits
        wide_sel = 4;
        fn_sel = wide_sel[1:0];
        cycle("trunc", 1'b0);
        check("trunc_out", 64'(out), 64'h4);
        check("trunc_sel", 64'(out_sel), 64'h0);

        // Hold with en=0
        fn_sel = 2'd2;
        cycle("hold_cap", 1'b0);
        en = 1'b0; c = 4'hF;
        cycle("hold", 1'b0);
        check("hold_out", 64'(out), 64'h9);
        check("hold_valid", 64'(out_valid), 64'h0);

        // Mid-operation asynchronous reset
        en = 1'b1; c = 4'h9; fn_sel = 2'd2;
        cycle("pre_rst", 1'b0);
        check("pre_rst_out", 64'(out), 64'h9);
        #2 rst_n = 1'b0;
        #1;
        m_out = 0; m_sel = 0; m_valid = 0; m_par = 0;
        check_all("async_rst");
        #1 rst_n = 1'b1;
        cycle("resume", 1'b0);
        check("resume_out", 64'(out), 64'h9);

        // Randomized traffic with between-edge disturbance
        for (int i = 0; i < 200; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            c = 4'($urandom); d = 4'($urandom);
            fn_sel = 2'($urandom);
            en = ($urandom_range(0, 3) != 0);
            cycle("rand", ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
